// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read side.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = reg_addr_t'(31);

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port at the ID/EX boundary: writeback bypass,
// hardwired zero register, stall (re-read held index) and flush (bubble).
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg,
    input  logic [DATA_WIDTH-1:0] mem [NUM_REGS],
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] read_addr_q
);

    reg_addr_t src;
    logic      src_in_range;
    reg_data_t looked_up;
    reg_data_t read_data_q, read_data_d;
    reg_addr_t read_addr_d;

    // A stalled instruction re-reads its own held index so a late writeback reaches it.
    assign src = stall ? read_addr_q : read_reg;

    if (NUM_REGS < 2 ** ADDR_WIDTH) begin : g_range_check
        assign src_in_range = (int'(src) < NUM_REGS);
    end else begin : g_full_range
        assign src_in_range = 1'b1;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        looked_up = '0;
        if (src_in_range && src != ZERO_REG) begin
            if (reg_write && write_reg == src) begin
                looked_up = write_data;
            end else begin
                looked_up = mem[src];
            end
        end
        read_data_d = flush ? '0 : looked_up;
        read_addr_d = flush ? ZERO_REG : src;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q <= '0;
            read_addr_q <= '0;
        end else begin
            read_data_q <= read_data_d;
            read_addr_q <= read_addr_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/regfile_reader.sv
// Register storage with one writeback port and two registered read ports
// feeding the ID/EX boundary.
module regfile_reader
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [ADDR_WIDTH-1:0] read_addr1_q,
    output logic [ADDR_WIDTH-1:0] read_addr2_q,
    output logic                  valid_out
);

    reg_data_t mem_q [NUM_REGS];
    logic      valid_q, valid_d;

    // NOTE: the storage array is reset on purpose: the architecture guarantees all registers read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_write && write_reg == reg_addr_t'(i) && reg_addr_t'(i) != ZERO_REG) begin
                    mem_q[i] <= write_data;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_out = valid_q;

    regfile_read_port u_port1 (
        .clk         (clk),
        .reset       (reset),
        .read_reg    (read_reg1),
        .mem         (mem_q),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .stall       (stall),
        .flush       (flush),
        .read_data   (read_data1),
        .read_addr_q (read_addr1_q)
    );

    regfile_read_port u_port2 (
        .clk         (clk),
        .reset       (reset),
        .read_reg    (read_reg2),
        .mem         (mem_q),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .stall       (stall),
        .flush       (flush),
        .read_data   (read_data2),
        .read_addr_q (read_addr2_q)
    );

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Read side of the CPU register storage.
- Holds NUM_REGS words of DATA_WIDTH bits and accepts one writeback write per cycle.
- Provides two registered read ports that feed the ID/EX boundary, with:
  - same-cycle writeback bypass,
  - a hardwired zero register,
  - stall (hold) and flush (bubble) controls from the hazard unit.

Parameters:
DATA_WIDTH, 64, width of each register and of the read/write data
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)
ZERO_REG, 31, index that always reads 0 and ignores writes

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
reg_write  input  1  writeback write enable
write_reg  input  ADDR_WIDTH  writeback destination index
write_data  input  DATA_WIDTH  writeback data
read_reg1  input  ADDR_WIDTH  port 1 source index (decode stage)
read_reg2  input  ADDR_WIDTH  port 2 source index (decode stage)
valid_in  input  1  decode stage holds a real instruction
stall  input  1  hold the ID/EX outputs this cycle
flush  input  1  replace the ID/EX outputs with a bubble this cycle
read_data1  output  DATA_WIDTH  registered port 1 data
read_data2  output  DATA_WIDTH  registered port 2 data
read_addr1_q  output  ADDR_WIDTH  index captured for port 1 (for the forwarding unit)
read_addr2_q  output  ADDR_WIDTH  index captured for port 2
valid_out  output  1  read_data*/read_addr*_q belong to a real instruction

Behaviour:
- Reset:
  - asserting reset (0) immediately clears every storage word.
  - Also clears read_data1/2, read_addr1_q/2_q and valid_out to 0.
  - Deassertion takes effect at the next rising edge.
- Storage write:
  - At the rising edge, if reg_write=1 and write_reg!=ZERO_REG, then mem[write_reg] <= write_data.
  - Writes to ZERO_REG are discarded.
- lookup(a):
  - 0 if a==ZERO_REG;
  - else write_data if reg_write=1 and write_reg==a (bypass of the same-edge write);
  - else mem[a].
- Source index each cycle:
  - src1 = stall ? read_addr1_q : read_reg1; src2 likewise.
- Edge update, in priority order:
  - flush=1: read_data1/2 <= 0, read_addr1_q/2_q <= ZERO_REG, valid_out <= 0. Flush wins over stall.
  - stall=1: read_addr*_q and valid_out hold. read_data1/2 <= lookup(src*), so a writeback that lands during a stall is visible to the held instruction.
  - Otherwise: read_addr*_q <= read_reg*, read_data* <= lookup(read_reg*), valid_out <= valid_in.
- Latency: exactly 1 cycle from read_reg*/valid_in to read_data*/valid_out.
- Data inputs are used regardless of valid_in; valid_in only propagates to valid_out.
- Both ports may name the same index; each resolves independently and identically.
- Out-of-range index (>= NUM_REGS, only possible if NUM_REGS < 2**ADDR_WIDTH) reads 0 and ignores writes.
- Reset asserted mid-stall or mid-flush: the reset values above apply immediately. No pending state survives.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS, ZERO_REG constants;
  - typedefs reg_addr_t (logic [ADDR_WIDTH-1:0]) and reg_data_t (logic [DATA_WIDTH-1:0]).
- One sub-module, regfile_read_port, is instantiated twice. Inputs: read_reg, the storage array view, the write-bypass signals, stall, flush. Outputs: read_data and read_addr_q.
- valid_out lives in the top.
- The storage array and write logic live in the top.

Test Plan:
- Reset: drive reset=0 mid-run, then release. Every output is 0, and reading indices 0..31 after release returns 0.
- Write then read: write 0x0123_4567_89AB_CDEF to X5. Next cycle read_reg1=5, read_reg2=5. One edge later both read_data = 0x0123_4567_89AB_CDEF, read_addr1_q=5, valid_out=valid_in.
- Same-edge bypass: reg_write=1, write_reg=7, write_data=0xDEAD_BEEF, with read_reg1=7 on the same cycle. Next edge read_data1=0xDEAD_BEEF.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to X31, then read X31 on both ports. Both read_data=0, including in the bypass case.
- Stall with late writeback:
  - Capture read_reg1=3 (X3=0x10), then assert stall for 2 cycles.
  - In stall cycle 1, write X3=0x20.
  - Expected: read_addr1_q stays 3, read_data1 becomes 0x20 after that edge, valid_out held.
- Flush vs stall: assert flush=1 and stall=1 together while valid_out=1. Next edge gives valid_out=0, read_data1/2=0, read_addr*_q=31.
